alu_writeback: RTL

ALU_WRITEBACK -- requirements
Module: alu_writeback

---
 rtl/alu_writeback.sv | 130 +++++++++++++
 1 files changed

// File: rtl/alu_writeback.sv
// alu_writeback: ALU result writeback stage.
//
// Accepts one ALU result per transfer (in_valid & in_ready) and, on the same
// edge, updates the accumulator, the masked status register, and/or pushes the
// result byte into a 2-entry memory write queue.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready result handshake (in_ready is registered)
//   alu_out           result byte
//   alu_flags         flags {z,c,s,o}
//   flag_we           per-bit status write mask {z,c,s,o}
//   acc_we            write alu_out to acc
//   mem_we            push alu_out into the write queue
//   acc               accumulator
//   status            status register {z,c,s,o}
//   wb_valid/wb_ready write queue head handshake
//   wb_data           write queue head byte
//   status_clr        synchronous status clear (only with STATUS_CLR_EN)
//
// Optional feature macro: STATUS_CLR_EN adds the status_clr input.

module alu_writeback (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] alu_out,
  input  logic [3:0] alu_flags,
  input  logic [3:0] flag_we,
  input  logic       acc_we,
  input  logic       mem_we,
  output logic [7:0] acc,
  output logic [3:0] status,
  output logic       wb_valid,
  input  logic       wb_ready,
`ifdef STATUS_CLR_EN
  input  logic       status_clr,
`endif
  output logic [7:0] wb_data
);

  logic [7:0] acc_q, acc_d;
  logic [3:0] status_q, status_d;
  logic [1:0] count_q, count_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic       in_ready_q, in_ready_d;
  logic [7:0] mem_q [2];

  logic accept;
  logic push;
  logic pop;

  // in_ready_q is a flop, so accept never depends combinationally on wb_ready.
  assign accept = in_valid & in_ready_q;
  assign push   = accept & mem_we;
  assign pop    = (count_q != 2'd0) & wb_ready;

  always_comb begin
    acc_d = acc_q;
    if (accept && acc_we) begin
      acc_d = alu_out;
    end
  end

  always_comb begin
    status_d = status_q;
    if (accept) begin
      status_d = (status_q & ~flag_we) | (alu_flags & flag_we);
    end
`ifdef STATUS_CLR_EN
    // Clear wins over a same-cycle masked flag update.
    if (status_clr) begin
      status_d = 4'h0;
    end
`endif
  end

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    // Registered ready: derived from next count so it is valid one edge ahead.
    in_ready_d = (count_d < 2'd2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= 8'h00;
      status_q   <= 4'h0;
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      status_q   <= status_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Queue storage is not reset; wb_data is meaningless while wb_valid is low.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= alu_out;
    end
  end

  assign acc      = acc_q;
  assign status   = status_q;
  assign in_ready = in_ready_q;
  assign wb_valid = (count_q != 2'd0);
  assign wb_data  = mem_q[rd_ptr_q];

endmodule
